speaker_i2s_driver: RTL
=======================

# speaker_i2s_driver

Downstream consumer of the volume level stage: turns a tone half-period and a volume amplitude code into a signed square-wave sample and streams it to an I2S stereo DAC (MCLK/LRCK/SCK/SDIN). The amplitude code is offset-binary (16'h8000 + magnitude), exactly as the volume stage produces it. All DAC clocks are derived from one free-running divider counter, so every output is synchronous to `clk`.

## Interface
- `NOTE_W`, 22: width of `note_div`.
- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `note_div` in NOTE_W: tone half-period in `clk` cycles; 0 = silence.
- `amp_code` in 16: amplitude, offset-binary; magnitude = `amp_code` − 16'h8000.
- `mute` in 1: forces sample to 0; tone phase keeps running.
- `mclk` out 1: DAC master clock, clk/4.
- `sck` out 1: serial bit clock, clk/16.
- `lrck` out 1: word select, clk/1024; 0 = left, 1 = right.
- `sdin` out 1: serial data, I2S format, MSB first.
- `frame_start` out 1: one-cycle pulse when a new stereo frame begins.

## Operation
- Divider: 10-bit counter `div_cnt`, +1 every clk, wraps 1023→0. `mclk` = `div_cnt[1]`, `sck` = `div_cnt[3]`, `lrck` = `div_cnt[9]`; each is registered, so `mclk`, `sck`, and `lrck` lag the counter by 1 clk, and `sdin` is aligned to them.
- Tone generator: `tone_cnt` (NOTE_W bits), `phase` (1 bit).
  - `note_div`≠0: if `tone_cnt` ≥ `note_div`−1, then `tone_cnt`←0 and `phase` toggles; otherwise `tone_cnt`+1. The ≥ compare makes a mid-count shrink of `note_div` toggle on the next clk, with no wrap.
  - `note_div`=0: `tone_cnt`←0, `phase`←0.
- Magnitude: `mag` = `amp_code`−16'h8000 if `amp_code` ≥ 16'h8000, else 0. Saturate to 16'h7FFF.
- Raw sample, signed 16-bit: 0 if `mute` or `note_div`=0; +`mag` if `phase`=1; −`mag` (two's complement) if `phase`=0.
- Frame latch: when `div_cnt` wraps to 0, the raw sample is captured into `frame_sample` and `frame_start` pulses. Both channels of that frame carry `frame_sample`.
- Serializer:
  - Slot index s = `div_cnt[8:4]` (0..31) within each half-frame.
  - s=0: `sdin`=0 (I2S one-bit delay).
  - s=1..16: `sdin` = `frame_sample[16−s]`.
  - s=17..31: `sdin`=0.
  - `sdin` changes only on the falling edge of `sck`.

## Timing
- Reset values: `div_cnt`, `tone_cnt`, `phase`, `frame_sample`, `mclk`, `sck`, `lrck`, `sdin`, `frame_start` all 0.
- After `rst_n` deasserts, first `frame_start` occurs 1024 clk later (at the wrap).
- Input-to-DAC latency: a change on `amp_code`/`mute`/`note_div` reaches `sdin` at the next frame boundary. It first appears in the left MSB 16–31 clk after that boundary; worst case ≈1024+32 clk.
- Mid-frame input changes never alter the frame being shifted out, so left and right always match.
- Simultaneous `frame_start` and `phase` toggle: the latched value is the pre-toggle sample.
- Async reset mid-frame: all outputs go to 0 immediately, with no partial word. Serialization restarts at `div_cnt`=0.
- `amp_code` < 16'h8000 is treated as silence-level magnitude 0, not an error.

## Structure
- Shared package `audio_pkg` holds:
  - `AMP_OFFSET` = 16'h8000 and `MAG_MAX` = 16'h7FFF.
  - Divider bit positions: `MCLK_BIT`=1, `SCK_BIT`=3, `LRCK_BIT`=9.
  - `SLOT_MSB`=1 and `SAMPLE_W`=16.
- One sub-module, `tone_square_gen`, holds `tone_cnt`, `phase`, the mag/saturate logic and the raw-sample mux. The top level keeps the divider, frame latch and serializer.

## Test plan
- Reset then idle with `note_div`=0, `amp_code`=16'h8000: `mclk`/`sck`/`lrck` periods are 4/16/1024 clk, `sdin` stays 0, `frame_start` occurs every 1024 clk.
- `note_div`=50000, `amp_code`=16'h8000+30000: `phase` toggles every 50000 clk. Decoded left = right = +30000 (16'h7530) or −30000 (16'h8AD0), switching every ≈49 frames.
- `amp_code`=16'h1234 with tone running: decoded samples are 0 in both channels.
- `amp_code` changes from 16'h8000+2000 to 16'h8000+4000 in the middle of the right half-frame: current frame shows ±2000 on both channels, and the next frame shows ±4000.
- `mute`=1 for 3 frames while the tone runs: those frames decode as 0. After release, sign continues per an uninterrupted `phase` reference model.
- `rst_n` pulses low at slot 8 of the left channel: all outputs 0 within the reset cycle. After release, the first `frame_start` comes 1024 clk later and the first word decodes correctly.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg
// Shared constants for the audio output path: amplitude code offset and
// magnitude ceiling, DAC clock divider bit positions, and serial word layout.
package audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int DIV_W    = 10;

    localparam logic [SAMPLE_W-1:0] AMP_OFFSET = 16'h8000;
    localparam logic [SAMPLE_W-1:0] MAG_MAX    = 16'h7FFF;

    // Divider bits that become the DAC clocks (clk/4, clk/16, clk/1024)
    localparam int MCLK_BIT = 1;
    localparam int SCK_BIT  = 3;
    localparam int LRCK_BIT = 9;

    // First slot of a half-frame that carries data (I2S one-bit delay)
    localparam int SLOT_MSB = 1;

    typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/tone_square_gen.sv
// tone_square_gen
// Square-wave tone source. Toggles a phase bit every note_div_i clocks and
// turns the offset-binary amplitude code into a signed +/- magnitude sample.
// Ports:
//   clk, rst_n    system clock, async active-low reset
//   note_div_i    tone half-period in clk cycles, 0 = silence
//   amp_code_i    amplitude, offset-binary (AMP_OFFSET + magnitude)
//   mute_i        forces the sample to 0, phase keeps running
//   sample_o      signed two's complement raw sample (combinational)
module tone_square_gen
    import audio_pkg::*;
#(
    parameter int NOTE_W = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NOTE_W-1:0] note_div_i,
    input  logic [15:0]       amp_code_i,
    input  logic              mute_i,
    output sample_t           sample_o
);

    localparam logic [NOTE_W-1:0] NOTE_ONE = NOTE_W'(1);

    logic [NOTE_W-1:0] tone_cnt_q, tone_cnt_d;
    logic              phase_q, phase_d;
    logic              silent;
    sample_t           mag_raw, mag;

    assign silent = (note_div_i == '0);

    // >= rather than == so a note_div shrink below the running count
    // toggles on the next clock instead of wrapping the counter.
    always_comb begin
        tone_cnt_d = tone_cnt_q + NOTE_ONE;
        phase_d    = phase_q;
        if (silent) begin
            tone_cnt_d = '0;
            phase_d    = 1'b0;
        end else if (tone_cnt_q >= (note_div_i - NOTE_ONE)) begin
            tone_cnt_d = '0;
            phase_d    = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt_q <= '0;
            phase_q    <= 1'b0;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            phase_q    <= phase_d;
        end
    end

    // Codes below the offset are treated as zero magnitude, not an error.
    always_comb begin
        mag_raw = (amp_code_i >= AMP_OFFSET) ? (amp_code_i - AMP_OFFSET) : '0;
        mag     = (mag_raw > MAG_MAX) ? MAG_MAX : mag_raw;
    end

    always_comb begin
        sample_o = '0;
        if (!mute_i && !silent) begin
            sample_o = phase_q ? mag : (~mag + sample_t'(1));
        end
    end

endmodule

// File: rtl/speaker_i2s_driver.sv
// speaker_i2s_driver
// Streams a square-wave tone to an I2S stereo DAC. One free-running 10-bit
// divider produces MCLK/SCK/LRCK; one sample is latched per stereo frame and
// shifted out MSB first on both channels.
// Ports:
//   clk, rst_n    100 MHz system clock, async active-low reset
//   note_div      tone half-period in clk cycles, 0 = silence
//   amp_code      amplitude, offset-binary
//   mute          forces the sample to 0
//   mclk          clk/4, sck clk/16, lrck clk/1024 (0 = left)
//   sdin          I2S serial data
//   frame_start   one-cycle pulse at the start of each stereo frame
module speaker_i2s_driver
    import audio_pkg::*;
#(
    parameter int NOTE_W = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NOTE_W-1:0] note_div,
    input  logic [15:0]       amp_code,
    input  logic              mute,
    output logic              mclk,
    output logic              sck,
    output logic              lrck,
    output logic              sdin,
    output logic              frame_start
);

    localparam logic [4:0] SLOT_FIRST = 5'(SLOT_MSB);
    localparam logic [4:0] SLOT_LAST  = 5'(SLOT_MSB + SAMPLE_W - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    sample_t          raw_sample;
    sample_t          frame_sample_q, frame_sample_d;
    logic             mclk_q, sck_q, lrck_q, sdin_q, frame_start_q;
    logic             sdin_d;
    logic             wrap;
    logic [4:0]       slot;
    logic [3:0]       bit_sel;

    tone_square_gen #(
        .NOTE_W (NOTE_W)
    ) u_tone (
        .clk        (clk),
        .rst_n      (rst_n),
        .note_div_i (note_div),
        .amp_code_i (amp_code),
        .mute_i     (mute),
        .sample_o   (raw_sample)
    );

    assign div_cnt_d = div_cnt_q + DIV_W'(1);
    assign wrap      = (div_cnt_q == {DIV_W{1'b1}});

    // The sample is captured on the same edge the counter returns to 0, so a
    // phase toggle on that edge is not yet visible: the pre-toggle value wins.
    assign frame_sample_d = wrap ? raw_sample : frame_sample_q;

    // Slots 1..16 carry bits 15..0. All outputs are registered from the same
    // counter value, so sdin moves together with the falling edge of sck.
    assign slot    = div_cnt_q[8:4];
    assign bit_sel = 4'(5'(SAMPLE_W) - slot);

    always_comb begin
        sdin_d = 1'b0;
        if (slot >= SLOT_FIRST && slot <= SLOT_LAST) begin
            sdin_d = frame_sample_q[bit_sel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q      <= '0;
            frame_sample_q <= '0;
            mclk_q         <= 1'b0;
            sck_q          <= 1'b0;
            lrck_q         <= 1'b0;
            sdin_q         <= 1'b0;
            frame_start_q  <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            frame_sample_q <= frame_sample_d;
            mclk_q         <= div_cnt_q[MCLK_BIT];
            sck_q          <= div_cnt_q[SCK_BIT];
            lrck_q         <= div_cnt_q[LRCK_BIT];
            sdin_q         <= sdin_d;
            frame_start_q  <= wrap;
        end
    end

    assign mclk        = mclk_q;
    assign sck         = sck_q;
    assign lrck        = lrck_q;
    assign sdin        = sdin_q;
    assign frame_start = frame_start_q;

endmodule
